freq_gate_ctrl: RTL and testbench

//   Measurement sequencer for the frequency counter. Holds the pulse divider in reset

---
 rtl/freq_gate_ctrl.sv | 124 ++++++++++++
 tb/tb_freq_gate_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// Frequency-counter measurement sequencer: holds the pulse divider in reset, opens a
// programmed gate window, counts synchronized pulse rises and hands the count out.
module freq_gate_ctrl #(
    parameter int GATE_W      = 32,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              pulse_in,
    output logic              div_rst,
    output logic              busy,
    output logic [CNT_W-1:0]  result,
    output logic              overflow,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [GATE_W-1:0]      timer_q, timer_d;
    logic [ARM_W-1:0]       arm_q, arm_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   sat_q, sat_d;
    logic [CNT_W-1:0]       result_q, result_d;
    logic                   ovf_q, ovf_d;
    logic                   rise;

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            prev_q   <= 1'b0;
            timer_q  <= '0;
            arm_q    <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            prev_q   <= sync_q[SYNC_STAGES-1];
            timer_q  <= timer_d;
            arm_q    <= arm_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        arm_d    = arm_q;
        count_d  = count_q;
        sat_d    = sat_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (!abort && start && gate_cycles != '0) begin
                    timer_d = gate_cycles;
                    arm_d   = '0;
                    count_d = '0;
                    sat_d   = 1'b0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (arm_q == ARM_LAST) begin
                    state_d = GATE;
                end else begin
                    arm_d = arm_q + ARM_W'(1);
                end
            end
            GATE: begin
                if (rise) begin
                    if (count_q == '1) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                timer_d = timer_q - GATE_W'(1);
                // The last gate cycle's own rise is folded into the published result.
                if (abort) begin
                    state_d = IDLE;
                end else if (timer_q == GATE_W'(1)) begin
                    result_d = count_d;
                    ovf_d    = sat_d;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (abort || result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign div_rst      = (state_q != GATE);
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign result       = result_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: a 32-bit and a 4-bit counter instance share stimulus;
// pulse_in is a free-running square wave with a 10-clock period.
module tb_freq_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] gate_cycles;
    logic        pulse_in;
    logic        result_ready;

    logic        div_rst, busy, overflow, result_valid;
    logic [31:0] result;
    logic        div_rst4, busy4, overflow4, result_valid4;
    logic [3:0]  result4;

    int checks = 0;
    int errors = 0;

    freq_gate_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_cycles(gate_cycles),
        .pulse_in(pulse_in), .div_rst(div_rst), .busy(busy), .result(result),
        .overflow(overflow), .result_valid(result_valid), .result_ready(result_ready)
    );

    freq_gate_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_cycles(gate_cycles),
        .pulse_in(pulse_in), .div_rst(div_rst4), .busy(busy4), .result(result4),
        .overflow(overflow4), .result_valid(result_valid4), .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    // Edges at t = 3 mod 10 stay clear of the clk rising edges at t = 5 mod 10.
    initial begin
        pulse_in = 1'b0;
        #3;
        forever begin
            pulse_in = 1'b1;
            #50;
            pulse_in = 1'b0;
            #50;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] gc);
        gate_cycles = gc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL accept: valid=%b busy=%b required valid=0 busy=0", result_valid, busy);
        end
    endtask

    task automatic check_done(input string name, input logic [31:0] exp_r, input logic exp_o,
                              input logic [3:0] exp_r4, input logic exp_o4);
        checks++;
        if (result_valid !== 1'b1 || result !== exp_r || overflow !== exp_o ||
            result4 !== exp_r4 || overflow4 !== exp_o4 || div_rst !== 1'b1) begin
            errors++;
            $display("FAIL %s: valid=%b result=%0d ovf=%b result4=%0d ovf4=%b div_rst=%b required valid=1 result=%0d ovf=%b result4=%0d ovf4=%b div_rst=1",
                     name, result_valid, result, overflow, result4, overflow4, div_rst,
                     exp_r, exp_o, exp_r4, exp_o4);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; gate_cycles = '0; result_ready = 1'b0;
        #22;
        checks++;
        if (div_rst !== 1'b1 || busy !== 1'b0 || result !== 32'd0 || overflow !== 1'b0 ||
            result_valid !== 1'b0 || result4 !== 4'd0) begin
            errors++;
            $display("FAIL reset: div_rst=%b busy=%b result=%0d ovf=%b valid=%b required 1 0 0 0 0",
                     div_rst, busy, result, overflow, result_valid);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_gate();
        do_start(32'd100);
        checks++;
        if (busy !== 1'b1 || div_rst !== 1'b1) begin
            errors++;
            $display("FAIL arm_entry: busy=%b div_rst=%b required 1 1", busy, div_rst);
        end
        tick(); tick();
        checks++;
        if (div_rst !== 1'b1) begin
            errors++;
            $display("FAIL arm_third_cycle: div_rst=%b required 1", div_rst);
        end
        tick();
        checks++;
        if (div_rst !== 1'b0) begin
            errors++;
            $display("FAIL gate_open: div_rst=%b required 0", div_rst);
        end
        repeat (99) tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b1 || div_rst !== 1'b0) begin
            errors++;
            $display("FAIL gate_last_cycle: valid=%b busy=%b div_rst=%b required 0 1 0",
                     result_valid, busy, div_rst);
        end
        tick();
        check_done("gate100", 32'd10, 1'b0, 4'd10, 1'b0);
        accept();
    endtask

    task automatic test_saturation();
        do_start(32'd400);
        repeat (403) tick();
        check_done("gate400_sat", 32'd40, 1'b0, 4'd15, 1'b1);
        accept();
    endtask

    task automatic test_zero_gate();
        do_start(32'd0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b0 || div_rst !== 1'b1 || result_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_gate[%0d]: busy=%b div_rst=%b valid=%b required 0 1 0",
                         i, busy, div_rst, result_valid);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        do_start(32'd100);
        repeat (3 + 49) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || div_rst !== 1'b1 ||
            result !== 32'd40 || result4 !== 4'd15 || overflow4 !== 1'b1) begin
            errors++;
            $display("FAIL abort_gate: busy=%b valid=%b div_rst=%b result=%0d result4=%0d ovf4=%b required 0 0 1 40 15 1",
                     busy, result_valid, div_rst, result, result4, overflow4);
        end
        repeat (5) tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle: valid=%b busy=%b required 0 0", result_valid, busy);
        end
        do_start(32'd20);
        repeat (23) tick();
        check_done("gate20_after_abort", 32'd2, 1'b0, 4'd2, 1'b0);
        accept();
    endtask

    task automatic test_idle_abort();
        abort = 1'b1;
        do_start(32'd50);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || div_rst !== 1'b1) begin
            errors++;
            $display("FAIL idle_abort_blocks_start: busy=%b div_rst=%b required 0 1", busy, div_rst);
        end
        tick();
    endtask

    task automatic test_back_to_back_hold();
        do_start(32'd30);
        repeat (33) tick();
        check_done("gate30", 32'd3, 1'b0, 4'd3, 1'b0);
        gate_cycles = 32'd7;
        for (int i = 0; i < 50; i++) begin
            start = (i >= 10 && i < 40);
            tick();
            checks++;
            if (result_valid !== 1'b1 || result !== 32'd3 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b result=%0d busy=%b required 1 3 1",
                         i, result_valid, result, busy);
            end
        end
        start = 1'b0;
        accept();
        tick();
        checks++;
        if (busy !== 1'b0 || result !== 32'd3) begin
            errors++;
            $display("FAIL no_pending_start: busy=%b result=%0d required 0 3", busy, result);
        end
    endtask

    task automatic test_async_reset();
        do_start(32'd100);
        repeat (3 + 20) tick();
        checks++;
        if (busy !== 1'b1 || div_rst !== 1'b0 || result !== 32'd3) begin
            errors++;
            $display("FAIL pre_reset_gate: busy=%b div_rst=%b result=%0d required 1 0 3",
                     busy, div_rst, result);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (div_rst !== 1'b1 || busy !== 1'b0 || result !== 32'd0 || overflow !== 1'b0 ||
            result_valid !== 1'b0 || result4 !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: div_rst=%b busy=%b result=%0d ovf=%b valid=%b required 1 0 0 0 0",
                     div_rst, busy, result, overflow, result_valid);
        end
        #2;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_gate();
        test_saturation();
        test_zero_gate();
        test_abort();
        test_idle_abort();
        test_back_to_back_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
